id_ctrl_unit: RTL and testbench

Instruction-decode controller for the Osiris I ID stage. It decodes the opcode of the instruction held in IF/ID and drives `imm_src` and the immediate field to the extend unit in the same cycle. It also generates the main control bundle and registers it into the ID/EX pipeline register under a valid/ready handshake, with flush and stall support. A two-state FSM blocks issue after an illegal instruction until the trap is acknowledged.

---
 rtl/osiris_pkg.sv | 42 ++++
 rtl/main_decoder.sv | 61 ++++++
 rtl/id_ctrl_unit.sv | 103 ++++++++++
 tb/tb_id_ctrl_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/osiris_pkg.sv
// rtl/osiris_pkg.sv - shared encodings and types for the Osiris I decode stage
package osiris_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational RV32I opcode decode into the control bundle
module main_decoder
    import osiris_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic [2:0] o_imm_src
);

    always_comb begin
        o_ctrl    = '0;
        o_imm_src = IMM_I;
        // full 7-bit compare also rejects compressed encodings (opcode[1:0] != 11)
        case (i_opcode)
            OPC_LUI, OPC_AUIPC: begin
                o_imm_src        = IMM_U;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                o_imm_src         = IMM_J;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.result_src = RES_PC4;
            end
            OPC_JALR: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jalr       = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_PC4;
            end
            OPC_BRANCH: begin
                o_imm_src     = IMM_B;
                o_ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_MEM;
            end
            OPC_STORE: begin
                o_imm_src        = IMM_S;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OPC_OPIMM: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.reg_write = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_unit.sv
// rtl/id_ctrl_unit.sv - ID-stage controller: decode, ID/EX register, handshake and trap FSM
module id_ctrl_unit
    import osiris_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int OFFSET = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WIDTH-1:0]        i_instr_ID,
    input  logic                    i_valid_ID,
    output logic                    o_ready_ID,
    output logic [2:0]              o_imm_src_ID,
    output logic [WIDTH-OFFSET-1:0] o_imm_ID,
    input  logic                    i_ready_EX,
    input  logic                    i_flush_EX,
    input  logic                    i_trap_ack,
    output logic                    o_valid_EX,
    output logic                    o_reg_write_EX,
    output logic                    o_mem_write_EX,
    output logic                    o_alu_src_EX,
    output logic                    o_branch_EX,
    output logic                    o_jump_EX,
    output logic                    o_jalr_EX,
    output logic [1:0]              o_result_src_EX,
    output logic                    o_illegal_EX,
    output logic                    o_trap_pending
);

    ctrl_t  w_ctrl;
    ctrl_t  r_ctrl;
    logic   r_valid;
    state_t r_state;
    state_t w_state_next;
    logic   w_advance;
    logic   w_accept;

    main_decoder u_main_decoder (
        .i_opcode  (i_instr_ID[6:0]),
        .o_ctrl    (w_ctrl),
        .o_imm_src (o_imm_src_ID)
    );

    assign o_imm_ID = i_instr_ID[WIDTH-1:OFFSET];

    // ready depends only on registered state and i_ready_EX, never on i_valid_ID
    assign w_advance  = !r_valid || i_ready_EX;
    assign o_ready_ID = w_advance && (r_state == ST_RUN);
    assign w_accept   = i_valid_ID && o_ready_ID && !i_flush_EX;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_flush_EX) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
        end else if (w_advance) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_ctrl.illegal) begin
                    w_state_next = ST_TRAP;
                end
            end
            ST_TRAP: begin
                if (i_trap_ack || i_flush_EX) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign o_valid_EX      = r_valid;
    assign o_reg_write_EX  = r_ctrl.reg_write;
    assign o_mem_write_EX  = r_ctrl.mem_write;
    assign o_alu_src_EX    = r_ctrl.alu_src;
    assign o_branch_EX     = r_ctrl.branch;
    assign o_jump_EX       = r_ctrl.jump;
    assign o_jalr_EX       = r_ctrl.jalr;
    assign o_result_src_EX = r_ctrl.result_src;
    assign o_illegal_EX    = r_ctrl.illegal;
    assign o_trap_pending  = (r_state == ST_TRAP);

endmodule

// File: tb/tb_id_ctrl_unit.sv
// tb/tb_id_ctrl_unit.sv - scoreboard bench for id_ctrl_unit
module tb_id_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid_id;
    logic        ready_id;
    logic [2:0]  imm_src;
    logic [24:0] imm;
    logic        ready_ex;
    logic        flush_ex;
    logic        trap_ack;
    logic        valid_ex;
    logic        rw, mw, as, br, jp, jr, ill, trap;
    logic [1:0]  rs;

    int checks   = 0;
    int failures = 0;

    // bundle order: reg_write mem_write alu_src branch jump jalr result_src[1:0] illegal
    logic [8:0] sb[$];

    localparam logic [8:0] B_ADDI = 9'b1_0_1_0_0_0_00_0;
    localparam logic [8:0] B_SW   = 9'b0_1_1_0_0_0_00_0;
    localparam logic [8:0] B_BEQ  = 9'b0_0_0_1_0_0_00_0;
    localparam logic [8:0] B_JAL  = 9'b1_0_0_0_1_0_10_0;
    localparam logic [8:0] B_LUI  = 9'b1_0_1_0_0_0_00_0;
    localparam logic [8:0] B_ILL  = 9'b0_0_0_0_0_0_00_1;

    id_ctrl_unit #(.WIDTH(32), .OFFSET(7)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_instr_ID      (instr),
        .i_valid_ID      (valid_id),
        .o_ready_ID      (ready_id),
        .o_imm_src_ID    (imm_src),
        .o_imm_ID        (imm),
        .i_ready_EX      (ready_ex),
        .i_flush_EX      (flush_ex),
        .i_trap_ack      (trap_ack),
        .o_valid_EX      (valid_ex),
        .o_reg_write_EX  (rw),
        .o_mem_write_EX  (mw),
        .o_alu_src_EX    (as),
        .o_branch_EX     (br),
        .o_jump_EX       (jp),
        .o_jalr_EX       (jr),
        .o_result_src_EX (rs),
        .o_illegal_EX    (ill),
        .o_trap_pending  (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: a bundle is consumed when valid and EX ready at the same edge
    always @(negedge clk) begin
        if (rst_n && valid_ex && ready_ex) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", {rw, mw, as, br, jp, jr, rs, ill});
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({rw, mw, as, br, jp, jr, rs, ill} !== e) begin
                    failures++;
                    $display("FAIL sb_bundle actual=%0h expected=%0h", {rw, mw, as, br, jp, jr, rs, ill}, e);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [31:0] ins, input logic [2:0] exp_imm, input logic [8:0] exp_b);
        logic [31:0] sh;
        valid_id = 1'b1;
        instr    = ins;
        sh       = ins >> 7;
        @(negedge clk);
        check({name, "_imm_src"}, {29'd0, imm_src}, {29'd0, exp_imm});
        check({name, "_imm"}, {7'd0, imm}, sh);
        check({name, "_ready_id"}, {31'd0, ready_id}, 32'd1);
        sb.push_back(exp_b);
        next_cycle();
        valid_id = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr = 32'h0; valid_id = 1'b0;
        ready_ex = 1'b1; flush_ex = 1'b0; trap_ack = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid_ex", {31'd0, valid_ex}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_ready_id", {31'd0, ready_id}, 32'd1);
        check("rst_bundle", {23'd0, rw, mw, as, br, jp, jr, rs, ill}, 32'd0);
        next_cycle();

        issue("addi", 32'h00500093, 3'b000, B_ADDI);
        issue("sw",   32'h0020A223, 3'b001, B_SW);
        issue("beq",  32'h00208463, 3'b010, B_BEQ);
        issue("jal",  32'h008000EF, 3'b011, B_JAL);
        next_cycle();

        // stall: LUI held in ID/EX while EX is not ready
        issue("lui", 32'h123450B7, 3'b100, B_LUI);
        ready_ex = 1'b0;
        valid_id = 1'b1;
        instr    = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready_id", {31'd0, ready_id}, 32'd0);
            check("stall_valid_ex", {31'd0, valid_ex}, 32'd1);
            check("stall_hold", {23'd0, rw, mw, as, br, jp, jr, rs, ill}, {23'd0, B_LUI});
            next_cycle();
        end
        ready_ex = 1'b1;
        issue("addi_after_stall", 32'h00500093, 3'b000, B_ADDI);

        // flush beats a valid instruction
        valid_id = 1'b1;
        instr    = 32'h002081B3;
        flush_ex = 1'b1;
        next_cycle();
        flush_ex = 1'b0;
        valid_id = 1'b0;
        @(negedge clk);
        check("flush_valid_ex", {31'd0, valid_ex}, 32'd0);
        check("flush_bundle", {23'd0, rw, mw, as, br, jp, jr, rs, ill}, 32'd0);
        next_cycle();

        // illegal instruction trap
        issue("illegal", 32'hFFFFFFFF, 3'b000, B_ILL);
        valid_id = 1'b1;
        instr    = 32'h00500093;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("trap_pending", {31'd0, trap}, 32'd1);
            check("trap_ready_id", {31'd0, ready_id}, 32'd0);
            next_cycle();
        end
        check("trap_drained", {31'd0, valid_ex}, 32'd0);
        trap_ack = 1'b1;
        @(negedge clk);
        check("ack_cycle_ready_id", {31'd0, ready_id}, 32'd0);
        next_cycle();
        trap_ack = 1'b0;
        check("ack_trap_clear", {31'd0, trap}, 32'd0);
        issue("addi_after_trap", 32'h00500093, 3'b000, B_ADDI);
        next_cycle();

        // reset while in TRAP with a valid bundle held
        ready_ex = 1'b0;
        issue("illegal_held", 32'hFFFFFFFF, 3'b000, B_ILL);
        @(negedge clk);
        check("pre_rst_trap", {31'd0, trap}, 32'd1);
        check("pre_rst_valid_ex", {31'd0, valid_ex}, 32'd1);
        next_cycle();
        rst_n = 1'b0;
        sb.delete();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid_ex", {31'd0, valid_ex}, 32'd0);
        check("mid_rst_trap", {31'd0, trap}, 32'd0);
        check("mid_rst_bundle", {23'd0, rw, mw, as, br, jp, jr, rs, ill}, 32'd0);
        check("mid_rst_ready_id", {31'd0, ready_id}, 32'd1);
        next_cycle();
        ready_ex = 1'b1;
        issue("addi_after_rst", 32'h00500093, 3'b000, B_ADDI);
        next_cycle();
        next_cycle();

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
